// File: rtl/sram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared definitions for the two-port SRAM arbiter: the sequencer state
// encoding, the requester port indices and a helper that turns the one-hot
// grant into a port index.
// ----------------------------------------------------------------------------
package sram_arbiter_pkg;

    // Sequencer states: wait for a request, drive the SRAM strobe, respond.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Port 0 is instruction fetch, port 1 is load/store.
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    // With only two ports, the grant is one-hot, so the LSU bit alone
    // names the winner.
    function automatic logic grant_index(input logic [1:0] gnt);
        return gnt[PORT_LSU];
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// ----------------------------------------------------------------------------
// sram_arbiter_if
// Bundles the two requester handshakes and the SRAM macro pins that the
// arbiter sits between.
//   req*/we*/addr*/wdata*  : requester -> arbiter
//   gnt*/rsp_valid*/rdata* : arbiter -> requester
//   sram_cs/we/addr/wdata  : arbiter -> SRAM macro
//   sram_rdata             : SRAM macro -> arbiter (registered in the macro)
//   busy                   : arbiter status, high while a transaction is open
// Modport slave is the arbiter side; master is the requester/SRAM side.
// ----------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int ADDR  = 8,
    parameter int WIDTH = 32
);
    logic             req0;
    logic             we0;
    logic [ADDR-1:0]  addr0;
    logic [WIDTH-1:0] wdata0;
    logic             gnt0;
    logic             rsp_valid0;
    logic [WIDTH-1:0] rdata0;

    logic             req1;
    logic             we1;
    logic [ADDR-1:0]  addr1;
    logic [WIDTH-1:0] wdata1;
    logic             gnt1;
    logic             rsp_valid1;
    logic [WIDTH-1:0] rdata1;

    logic             sram_cs;
    logic             sram_we;
    logic [ADDR-1:0]  sram_addr;
    logic [WIDTH-1:0] sram_wdata;
    logic [WIDTH-1:0] sram_rdata;

    logic             busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        output gnt0, rsp_valid0, rdata0,
        input  req1, we1, addr1, wdata1,
        output gnt1, rsp_valid1, rdata1,
        output sram_cs, sram_we, sram_addr, sram_wdata,
        input  sram_rdata,
        output busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        input  gnt0, rsp_valid0, rdata0,
        output req1, we1, addr1, wdata1,
        input  gnt1, rsp_valid1, rdata1,
        input  sram_cs, sram_we, sram_addr, sram_wdata,
        output sram_rdata,
        input  busy
    );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
//   req_i      : request vector, bit 0 = fetch, bit 1 = load/store
//   last_gnt_i : port that won the previous grant
//   gnt_o      : one-hot grant (all zero when nobody requests)
// A lone requester always wins; under contention the port that did not win
// last time is chosen.
// ----------------------------------------------------------------------------
module rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[PORT_FETCH] && req_i[PORT_LSU]) begin
            if (last_gnt_i == PORT_LSU) begin
                gnt_o[PORT_FETCH] = 1'b1;
            end else begin
                gnt_o[PORT_LSU] = 1'b1;
            end
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------------------
// sram_arbiter
// Arbitrates the fetch and load/store ports onto a single-port SRAM macro
// and sequences each access as IDLE (grant) -> ACCESS (strobe) -> RESP
// (response), i.e. at most one transaction every three cycles.
//   clk   : system clock, everything on posedge
//   rst_n : asynchronous active-low reset
//   bus   : requester handshakes, SRAM pins and busy (slave modport)
// ----------------------------------------------------------------------------
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR  = 8,
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_gnt_q, last_gnt_d;
    logic             cs_q, cs_d;
    logic             we_q, we_d;
    logic             rd_q, rd_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;

    logic [1:0]       req_vec;
    logic [1:0]       arb_gnt;
    logic [1:0]       gnt;
    logic [1:0]       rsp;
    logic             win;

    // Requests are masked during reset so the combinational grant stays low
    // while rst_n is asserted.
    assign req_vec = {bus.req1, bus.req0} & {2{rst_n}};

    rr_arb2 u_arb (
        .req_i      (req_vec),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (arb_gnt)
    );

    assign win = grant_index(arb_gnt);

    // State and datapath registers. last_gnt resets to the LSU port so the
    // fetch port wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= PORT_FETCH;
            last_gnt_q <= PORT_LSU;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_gnt_q <= last_gnt_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Next-state and output decode. rd_q remembers the direction after
    // sram_we has been dropped, so RESP knows whether to capture read data.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_gnt_d = last_gnt_q;
        cs_d       = cs_q;
        we_d       = we_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        gnt        = 2'b00;
        rsp        = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    gnt        = arb_gnt;
                    sel_d      = win;
                    last_gnt_d = win;
                    cs_d       = 1'b1;
                    if (win == PORT_LSU) begin
                        we_d    = bus.we1;
                        addr_d  = bus.addr1;
                        wdata_d = bus.wdata1;
                    end else begin
                        we_d    = bus.we0;
                        addr_d  = bus.addr0;
                        wdata_d = bus.wdata0;
                    end
                    rd_d    = !we_d;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                cs_d    = 1'b0;
                we_d    = 1'b0;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                rsp[sel_q] = 1'b1;
                if (rd_q) begin
                    if (sel_q == PORT_LSU) begin
                        rdata1_d = bus.sram_rdata;
                    end else begin
                        rdata0_d = bus.sram_rdata;
                    end
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // rdata is taken from the next-state value so that read data reaches
    // the requester in the same cycle as rsp_valid; the register then holds
    // it until the next read on that port.
    assign bus.gnt0       = gnt[PORT_FETCH];
    assign bus.gnt1       = gnt[PORT_LSU];
    assign bus.rsp_valid0 = rsp[PORT_FETCH];
    assign bus.rsp_valid1 = rsp[PORT_LSU];
    assign bus.rdata0     = rdata0_d;
    assign bus.rdata1     = rdata1_d;
    assign bus.sram_cs    = cs_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port SRAM macro (registered read data, one-cycle read latency, CS/WE strobes).
- Port 0 is instruction fetch; port 1 is load/store.
- Requesters use a req/gnt handshake; the block drives SRAM CS/WE/addr/data_in and returns read data with a one-cycle rsp_valid pulse.
- Sits between the CPU core and SRAM; owns every SRAM strobe.

Parameters:
ADDR, 8, SRAM address width
WIDTH, 32, data word width

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
req0  in  1  port 0 request
we0  in  1  port 0 write enable (1 = write, 0 = read)
addr0  in  ADDR  port 0 address
wdata0  in  WIDTH  port 0 write data
gnt0  out  1  port 0 request accepted (1-cycle pulse)
rsp_valid0  out  1  port 0 transaction complete (1-cycle pulse)
rdata0  out  WIDTH  port 0 read data, valid with rsp_valid0
req1, we1, addr1, wdata1, gnt1, rsp_valid1, rdata1: same as port 0, for port 1
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR  SRAM address
sram_wdata  out  WIDTH  SRAM data_in
sram_rdata  in  WIDTH  SRAM data_out (registered in macro)
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE.
  - All outputs 0: gnt*, rsp_valid*, rdata*, sram_*, busy.
  - last_gnt = 1, so port 0 wins the first contention.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select the winner, pulse its gnt for one cycle, register the winner's we/addr/wdata into sram_we/sram_addr/sram_wdata, set sram_cs = 1, set sel = winner, go to ACCESS.
  - With no req, stay in IDLE with sram_cs = 0.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: winner = !last_gnt (round-robin), and last_gnt updates to the winner.
  - A single uncontended request also updates last_gnt.
- ACCESS (one cycle):
  - SRAM samples cs/we/addr/wdata on this edge.
  - On exit, sram_cs and sram_we clear to 0; go to RESP.
- RESP (one cycle):
  - For a read, capture sram_rdata into rdata[sel].
  - Pulse rsp_valid[sel]; reads and writes both complete here.
  - Go to IDLE.
  - rdata[sel] holds its value until the next read on the same port; writes leave rdata unchanged.
- Timing, with gnt asserted in cycle T:
  - SRAM strobe active in cycle T+1.
  - rsp_valid and rdata valid in cycle T+2.
  - Next gnt no earlier than cycle T+3, so peak throughput is one transaction per 3 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Deassert req the cycle after gnt, or keep it high to queue another transaction.
  - A req that is still high when the FSM returns to IDLE is a new request.
- gnt0 and gnt1 are never high together; likewise rsp_valid0 and rsp_valid1.
- Requests arriving in ACCESS or RESP are ignored until IDLE; no gnt is issued outside IDLE.
- Reset mid-transaction: the in-flight transaction is aborted, no rsp_valid is issued, and the FSM restarts in IDLE. A write strobe already sampled by the SRAM is not rolled back.
- Addresses pass through unmodified at the full ADDR width, with no wrap or offset logic.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2
  - port index constants PORT_FETCH = 1'b0, PORT_LSU = 1'b1
- Sub-module rr_arb2: combinational 2-way round-robin pick from req[1:0] and last_gnt, producing a one-hot grant.
- The top level holds the FSM, the request registers and the response routing.

Test Plan:
- Port 0 read only: after reset, req0 = 1, we0 = 0, addr0 = 8'h10, with SRAM holding 32'hDEADBEEF at 8'h10 -> gnt0 in cycle T; sram_cs = 1, sram_we = 0 and sram_addr = 8'h10 in T+1; rsp_valid0 = 1 and rdata0 = 32'hDEADBEEF in T+2.
- Port 1 write then read: we1 = 1, addr1 = 8'h20, wdata1 = 32'h12345678, then read 8'h20 -> write strobe with matching sram_wdata; the read returns rdata1 = 32'h12345678; rdata0 unchanged.
- Contention: req0 and req1 both held high for 4 transactions from reset -> grant order 0, 1, 0, 1; gnt0 and gnt1 never coincide.
- Back-to-back: req0 held continuously -> gnt0 pulses every 3 cycles; busy drops for exactly one cycle between transactions.
- Reset in ACCESS: assert rst_n = 0 during cycle T+1 of a read -> outputs 0 immediately (asynchronous), no rsp_valid0 afterwards, and the first request after release is granted to port 0.
- Late request: req1 rises while in ACCESS -> no gnt1 until the FSM is back in IDLE, then gnt1 in the IDLE cycle.
